// File: rtl/proj_lut_cell_k.sv
// proj_lut_cell_k: K-input LUT cell with optional output flop and serial config chain.
// Define CFG_PARITY_EN to append an even-parity bit to the image and add the ERR state.
module proj_lut_cell_k #(
  parameter int K = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [K-1:0] x_i,
  input  logic         cfg_en_i,
  input  logic         cfg_value_i,
  output logic         cfg_value_o,
  output logic         cfg_done_o,
  output logic         cfg_err_o,
  output logic         out_o
);

  localparam int LUT_W = 2 ** K;
`ifdef CFG_PARITY_EN
  localparam int CFG_W = LUT_W + 3;
`else
  localparam int CFG_W = LUT_W + 2;
`endif
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int SEL_B = LUT_W;
  localparam int INIT_B = LUT_W + 1;

  typedef enum logic [1:0] {
    S_UNCONF,
    S_LOAD,
    S_RUN
`ifdef CFG_PARITY_EN
    ,
    S_ERR
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flop_q, flop_d;

  logic [LUT_W-1:0] table_w;
  logic             lut_w;
  logic             sel_w;
  logic             init_w;
  logic             full_w;
  logic             run_w;

  assign table_w = cfg_q[LUT_W-1:0];
  assign lut_w   = table_w[x_i];
  assign sel_w   = cfg_q[SEL_B];
  assign init_w  = cfg_q[INIT_B];
  assign full_w  = (cnt_q == CNT_FULL);
  assign run_w   = (state_q == S_RUN);

`ifdef CFG_PARITY_EN
  logic img_ok_w;
  assign img_ok_w = ~^cfg_q;
`endif

  // State, image, bit count and output flop registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_UNCONF;
      cfg_q   <= '0;
      cnt_q   <= '0;
      flop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      flop_q  <= flop_d;
    end
  end

  // Shift chain, load/run sequencing and flop update
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    flop_d  = flop_q;

    if (cfg_en_i) begin
      cfg_d = {cfg_value_i, cfg_q[CFG_W-1:1]};
    end

    unique case (state_q)
      S_UNCONF: begin
        if (cfg_en_i) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ONE;
        end
      end
      S_LOAD: begin
        if (cfg_en_i) begin
          if (!full_w) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (full_w) begin
`ifdef CFG_PARITY_EN
          state_d = img_ok_w ? S_RUN : S_ERR;
`else
          state_d = S_RUN;
`endif
          flop_d  = init_w;
        end
      end
      S_RUN: begin
        if (cfg_en_i) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ONE;
        end else begin
          flop_d = lut_w;
        end
      end
`ifdef CFG_PARITY_EN
      S_ERR: begin
        if (cfg_en_i) begin
          state_d = S_LOAD;
          cnt_d   = CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = S_UNCONF;
      end
    endcase
  end

  assign cfg_value_o = cfg_q[0];
  assign cfg_done_o  = run_w;
`ifdef CFG_PARITY_EN
  assign cfg_err_o   = (state_q == S_ERR);
`else
  assign cfg_err_o   = 1'b0;
`endif
  assign out_o       = run_w & (sel_w ? flop_q : lut_w);

endmodule

// File: tb/tb_proj_lut_cell_k.sv
// tb_proj_lut_cell_k: bench for the LUT cell with a shift-image model.
// Covers comb/registered LUT, partial load, chaining, reset and a K=4 sweep.
`timescale 1ns/1ps
module tb_proj_lut_cell_k;

`ifdef CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LW = 4;
  localparam int CW = LW + 2 + PAR;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0] x = '0;
  logic en = 1'b0, vi = 1'b0;
  logic vo, done, err, out;

  logic [1:0] cx = '0;
  logic cen = 1'b0, cvi = 1'b0;
  logic mid, c0_done, c0_err, c0_out;
  logic c1_vo, c1_done, c1_err, c1_out;

  logic [3:0] x4 = '0;
  logic en4 = 1'b0, vi4 = 1'b0;
  logic vo4, done4, err4, out4;

  int total = 0;
  int bad = 0;

  proj_lut_cell_k #(.K(2)) dut (
    .clk_i(clk), .rst_i(rst), .x_i(x),
    .cfg_en_i(en), .cfg_value_i(vi),
    .cfg_value_o(vo), .cfg_done_o(done),
    .cfg_err_o(err), .out_o(out)
  );

  proj_lut_cell_k #(.K(2)) c0 (
    .clk_i(clk), .rst_i(rst), .x_i(cx),
    .cfg_en_i(cen), .cfg_value_i(cvi),
    .cfg_value_o(mid), .cfg_done_o(c0_done),
    .cfg_err_o(c0_err), .out_o(c0_out)
  );

  proj_lut_cell_k #(.K(2)) c1 (
    .clk_i(clk), .rst_i(rst), .x_i(cx),
    .cfg_en_i(cen), .cfg_value_i(mid),
    .cfg_value_o(c1_vo), .cfg_done_o(c1_done),
    .cfg_err_o(c1_err), .out_o(c1_out)
  );

  proj_lut_cell_k #(.K(4)) d4 (
    .clk_i(clk), .rst_i(rst), .x_i(x4),
    .cfg_en_i(en4), .cfg_value_i(vi4),
    .cfg_value_o(vo4), .cfg_done_o(done4),
    .cfg_err_o(err4), .out_o(out4)
  );

  always #5 clk = ~clk;

  // model of the single K=2 cell: last CW bits shifted, index i = image bit i
  bit m_img[CW];
  int m_cnt = 0;
  bit m_ld = 0;
  bit m_run = 0;
  bit m_err = 0;
  bit m_flop = 0;
  bit m_par = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_img[i]) m_img[i] = 1'b0;
      m_cnt = 0;
      m_ld = 0;
      m_run = 0;
      m_err = 0;
      m_flop = 0;
    end else if (en) begin
      m_cnt = m_ld ? ((m_cnt < CW) ? m_cnt + 1 : CW) : 1;
      m_ld = 1;
      m_run = 0;
      m_err = 0;
      for (int i = 0; i < CW - 1; i++) m_img[i] = m_img[i+1];
      m_img[CW-1] = vi;
    end else if (m_ld && m_cnt == CW) begin
      m_par = 0;
      foreach (m_img[i]) m_par ^= m_img[i];
      m_ld = 0;
      m_flop = m_img[LW+1];
      if (PAR == 1 && m_par) m_err = 1;
      else m_run = 1;
    end else if (m_run) begin
      m_flop = m_img[x];
    end
  end

  function automatic bit m_out();
    if (!m_run) return 1'b0;
    return m_img[LW] ? m_flop : m_img[x];
  endfunction

  task automatic check(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_done", done, m_run);
    check("m_err", err, m_err);
    check("m_vo", vo, m_img[0]);
    check("m_out", out, m_out());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input int w, input bit b);
    if (w == 0) begin
      en = 1'b1;
      vi = b;
    end else if (w == 1) begin
      cen = 1'b1;
      cvi = b;
    end else begin
      en4 = 1'b1;
      vi4 = b;
    end
    cyc();
  endtask

  task automatic idle();
    en = 1'b0;
    cen = 1'b0;
    en4 = 1'b0;
    cyc();
  endtask

  task automatic load(input int w, input bq_t img);
    foreach (img[i]) shift(w, img[i]);
    idle();
  endtask

  function automatic bq_t img_k(input bit [15:0] t, input int n,
                                input bit sel, input bit ini);
    bq_t q;
    bit p;
    p = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(t[i]);
    q.push_back(sel);
    q.push_back(ini);
    if (PAR == 1) begin
      foreach (q[i]) p ^= q[i];
      q.push_back(p);
    end
    return q;
  endfunction

  initial begin
    bq_t a;
    bq_t b;
    bq_t q;
    bit [15:0] t4;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_vo", vo, 1'b0);
    check("rst_out", out, 1'b0);

    // AND, combinational
    a = img_k(16'h0008, 4, 1'b0, 1'b0);
    load(0, a);
    check("and_done", done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      x = 2'(i);
      #1;
      check($sformatf("and_x%0d", i), out, i == 3);
    end
    check("pin_model_and", m_out(), 1'b1);

    // reconfigure from RUN, then reset mid-load
    cyc();
    en = 1'b1;
    vi = 1'b0;
    cyc();
    check("reconf_out", out, 1'b0);
    check("reconf_done", done, 1'b0);
    shift(0, 1'b1);
    shift(0, 1'b0);
    rst = 1'b1;
    #2;
    check("rstmid_out", out, 1'b0);
    check("rstmid_done", done, 1'b0);
    check("rstmid_vo", vo, 1'b0);
    check("rstmid_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    for (int i = 0; i < CW - 1; i++) shift(0, a[i]);
    idle();
    check("short_done", done, 1'b0);
    shift(0, a[CW-1]);
    idle();
    check("resume_done", done, 1'b1);
    check("resume_out", out, 1'b1);

    // XOR, registered with init=1
    x = 2'd0;
    load(0, img_k(16'h0006, 4, 1'b1, 1'b1));
    check("xor_done", done, 1'b1);
    check("xor_init", out, 1'b1);
    x = 2'd1;
    cyc();
    check("xor_x1", out, 1'b1);
    x = 2'd3;
    #1;
    check("xor_hold", out, 1'b1);
    cyc();
    check("xor_x3", out, 1'b0);
    check("pin_model_xor", m_out(), 1'b0);

    // partial load with a pause
    for (int i = 0; i < 3; i++) shift(0, a[i]);
    repeat (5) idle();
    check("part_done", done, 1'b0);
    check("part_out", out, 1'b0);
    for (int i = 3; i < CW; i++) shift(0, a[i]);
    idle();
    check("part_done2", done, 1'b1);
    check("part_out2", out, 1'b1);

    // two-cell chain: first image lands downstream
    a = img_k(16'h0007, 4, 1'b0, 1'b0);
    b = img_k(16'h0006, 4, 1'b0, 1'b0);
    q = {a, b};
    load(1, q);
    check("ch_c0_done", c0_done, 1'b1);
    check("ch_c1_done", c1_done, 1'b1);
    check("ch_c0_err", c0_err, 1'b0);
    check("ch_c1_err", c1_err, 1'b0);
    check("ch_c1_vo", c1_vo, 1'b1);
    check("ch_c0_vo", mid, 1'b0);
    cx = 2'd0;
    #1;
    check("ch_x0_c1", c1_out, 1'b1);
    check("ch_x0_c0", c0_out, 1'b0);
    cx = 2'd2;
    #1;
    check("ch_x2_c1", c1_out, 1'b1);
    check("ch_x2_c0", c0_out, 1'b1);
    cx = 2'd3;
    #1;
    check("ch_x3_c1", c1_out, 1'b0);
    check("ch_x3_c0", c0_out, 1'b0);

    // K=4 sweep
    t4 = 16'hA5C3;
    cyc();
    load(2, img_k(t4, 16, 1'b0, 1'b0));
    check("k4_done", done4, 1'b1);
    check("k4_err", err4, 1'b0);
    check("k4_vo", vo4, t4[0]);
    for (int i = 0; i < 16; i++) begin
      x4 = 4'(i);
      #1;
      check($sformatf("k4_x%0d", i), out4, t4[i]);
    end

`ifdef CFG_PARITY_EN
    // bad parity, then a good reload
    cyc();
    a = img_k(16'h0008, 4, 1'b0, 1'b0);
    a[a.size()-1] = ~a[a.size()-1];
    x = 2'd3;
    load(0, a);
    check("par_err", err, 1'b1);
    check("par_done", done, 1'b0);
    check("par_out", out, 1'b0);
    a[a.size()-1] = ~a[a.size()-1];
    shift(0, a[0]);
    check("par_clr", err, 1'b0);
    for (int i = 1; i < CW; i++) shift(0, a[i]);
    idle();
    check("par_ok_err", err, 1'b0);
    check("par_ok_done", done, 1'b1);
    check("par_ok_out", out, 1'b1);
`endif

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
